tff_counter: RTL and testbench

- Parametrised synchronous counter built from a bank of toggle flip-flop cells.
- Generalises the single T flip-flop to a WIDTH-bit counter with:
  - programmable modulus
  - up/down mode
  - count enable
  - synchronous parallel load
  - terminal-count and wrap indications
- Used as the standard counter/divider primitive in lab designs: clock dividers, BCD digits, timers.

---
 rtl/tff_counter_pkg.sv | 19 +
 rtl/tff_counter_tff_cell.sv | 27 ++
 rtl/tff_counter.sv | 81 ++++++++
 tb/tb_tff_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_counter_pkg.sv
// Shared definitions for the toggle-flip-flop counter: direction encoding and
// the parameter legality check used at elaboration.
package tff_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // MODULO must be between 2 and 2**WIDTH inclusive.
   function automatic bit modulo_ok(input int width, input longint modulo);
      if (width < 1 || modulo < 2) begin
         return 1'b0;
      end
      if (width >= 62) begin
         return 1'b1;
      end
      return modulo <= (longint'(1) << width);
   endfunction

endpackage

// File: rtl/tff_counter_tff_cell.sv
// Single toggle flip-flop: q flips on the rising edge whenever t is high,
// asynchronous active-low reset to 0.
module tff_cell (
   input  logic clock,
   input  logic reset,
   input  logic t,
   output logic q
);

   logic q_d;
   logic q_q;

   always_comb begin
      q_d = q_q ^ t;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tff_counter.sv
// Modulo-N up/down counter built from a bank of T flip-flops, with parallel
// load (saturating), count enable, combinational terminal count and wrap pulse.
module tff_counter
   import tff_counter_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int MODULO = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrapped
);

   if (!modulo_ok(WIDTH, longint'(MODULO))) begin : g_bad_params
      $error("tff_counter: MODULO must lie in 2..2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] toggle;
   logic             at_max;
   logic             at_zero;
   logic             wrapped_d;
   logic             wrapped_q;

   always_comb begin
      at_max    = (count == MAX_VAL);
      at_zero   = (count == '0);
      tc        = en & ~load & (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));
      count_d   = count;
      wrapped_d = 1'b0;
      if (load) begin
         count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (en) begin
         if (up == DIR_UP) begin
            if (at_max) begin
               count_d   = '0;
               wrapped_d = 1'b1;
            end else begin
               count_d = count + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               count_d   = MAX_VAL;
               wrapped_d = 1'b1;
            end else begin
               count_d = count - WIDTH'(1);
            end
         end
      end
      // A bit toggles exactly where the chosen next state differs from now.
      toggle = count ^ count_d;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cells
      tff_cell u_cell (
         .clock (clock),
         .reset (reset),
         .t     (toggle[i]),
         .q     (count[i])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrapped_q <= 1'b0;
      end else begin
         wrapped_q <= wrapped_d;
      end
   end

   assign wrapped = wrapped_q;

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: a WIDTH=4/MODULO=10 instance plus two
// cascaded WIDTH=4/MODULO=16 instances forming an 8-bit counter.
module tb_tff_counter;

   logic       clock;
   logic       reset;

   logic       a_en;
   logic       a_up;
   logic       a_load;
   logic [3:0] a_load_val;
   logic [3:0] a_count;
   logic       a_tc;
   logic       a_wrapped;

   logic       c_en;
   logic       c_load;
   logic [3:0] c_lo_val;
   logic [3:0] c_hi_val;
   logic [3:0] lo_count;
   logic [3:0] hi_count;
   logic       lo_tc;
   logic       hi_tc;
   logic       lo_wrapped;
   logic       hi_wrapped;

   int checks;
   int failures;

   tff_counter #(.WIDTH(4), .MODULO(10)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .en       (a_en),
      .up       (a_up),
      .load     (a_load),
      .load_val (a_load_val),
      .count    (a_count),
      .tc       (a_tc),
      .wrapped  (a_wrapped)
   );

   tff_counter #(.WIDTH(4), .MODULO(16)) u_lo (
      .clock    (clock),
      .reset    (reset),
      .en       (c_en),
      .up       (1'b1),
      .load     (c_load),
      .load_val (c_lo_val),
      .count    (lo_count),
      .tc       (lo_tc),
      .wrapped  (lo_wrapped)
   );

   tff_counter #(.WIDTH(4), .MODULO(16)) u_hi (
      .clock    (clock),
      .reset    (reset),
      .en       (lo_tc),
      .up       (1'b1),
      .load     (c_load),
      .load_val (c_hi_val),
      .count    (hi_count),
      .tc       (hi_tc),
      .wrapped  (hi_wrapped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [3:0] pre;
      logic [3:0] dn_pre [3];
      logic       dn_tc  [3];
      logic [3:0] dn_cnt [3];
      logic       dn_wr  [3];

      checks     = 0;
      failures   = 0;
      reset      = 1'b0;
      a_en       = 1'b0;
      a_up       = 1'b1;
      a_load     = 1'b0;
      a_load_val = 4'd0;
      c_en       = 1'b0;
      c_load     = 1'b0;
      c_lo_val   = 4'd0;
      c_hi_val   = 4'd0;

      // Reset state
      #3;
      check("reset_count", 8'(a_count), 8'd0);
      check("reset_wrapped", 8'(a_wrapped), 8'd0);
      check("reset_tc", 8'(a_tc), 8'd0);
      step();
      reset = 1'b1;

      // Count to 7, then async reset between edges
      a_en = 1'b1;
      a_up = 1'b1;
      repeat (7) step();
      check("pre_reset_count7", 8'(a_count), 8'd7);
      #2 reset = 1'b0;
      #1;
      check("async_reset_count", 8'(a_count), 8'd0);
      check("async_reset_wrapped", 8'(a_wrapped), 8'd0);
      #1 reset = 1'b1;
      step();
      check("resume_count1", 8'(a_count), 8'd1);
      step();
      check("resume_count2", 8'(a_count), 8'd2);

      // Load 0, then count up 12 clocks: 1..9,0,1,2
      a_load     = 1'b1;
      a_load_val = 4'd0;
      step();
      a_load = 1'b0;
      check("load0_count", 8'(a_count), 8'd0);
      for (int i = 0; i < 12; i++) begin
         pre = 4'(i % 10);
         check($sformatf("up_tc_%0d", i), 8'(a_tc), (pre == 4'd9) ? 8'd1 : 8'd0);
         step();
         check($sformatf("up_count_%0d", i), 8'(a_count), 8'((i + 1) % 10));
         check($sformatf("up_wrapped_%0d", i), 8'(a_wrapped), (pre == 4'd9) ? 8'd1 : 8'd0);
      end
      check("up_final_count", 8'(a_count), 8'd2);

      // Count down from 1: 0, 9, 8
      a_load     = 1'b1;
      a_load_val = 4'd1;
      step();
      a_load = 1'b0;
      a_up   = 1'b0;
      dn_pre = '{4'd1, 4'd0, 4'd9};
      dn_tc  = '{1'b0, 1'b1, 1'b0};
      dn_cnt = '{4'd0, 4'd9, 4'd8};
      dn_wr  = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dn_pre_%0d", i), 8'(a_count), 8'(dn_pre[i]));
         check($sformatf("dn_tc_%0d", i), 8'(a_tc), 8'(dn_tc[i]));
         step();
         check($sformatf("dn_count_%0d", i), 8'(a_count), 8'(dn_cnt[i]));
         check($sformatf("dn_wrapped_%0d", i), 8'(a_wrapped), 8'(dn_wr[i]));
      end

      // Saturating load with en high, then wrap up from 9
      a_load     = 1'b1;
      a_load_val = 4'd13;
      a_up       = 1'b1;
      #1;
      check("load_tc_masked", 8'(a_tc), 8'd0);
      step();
      check("sat_load_count", 8'(a_count), 8'd9);
      check("sat_load_wrapped", 8'(a_wrapped), 8'd0);
      a_load = 1'b0;
      #1;
      check("sat_tc", 8'(a_tc), 8'd1);
      step();
      check("sat_wrap_count", 8'(a_count), 8'd0);
      check("sat_wrap_wrapped", 8'(a_wrapped), 8'd1);

      // Hold at 4 for 5 clocks while toggling up
      a_load     = 1'b1;
      a_load_val = 4'd4;
      step();
      a_load = 1'b0;
      a_en   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_up = i[0];
         #1;
         check($sformatf("hold_tc_%0d", i), 8'(a_tc), 8'd0);
         step();
         check($sformatf("hold_count_%0d", i), 8'(a_count), 8'd4);
         check($sformatf("hold_wrapped_%0d", i), 8'(a_wrapped), 8'd0);
      end

      // Hold at 0 counting down: tc must stay low while disabled
      a_load     = 1'b1;
      a_load_val = 4'd0;
      step();
      a_load = 1'b0;
      a_up   = 1'b0;
      #1;
      check("hold0_tc", 8'(a_tc), 8'd0);
      step();
      check("hold0_count", 8'(a_count), 8'd0);
      check("hold0_wrapped", 8'(a_wrapped), 8'd0);

      // Cascade: 0x0F -> 0x10
      c_load   = 1'b1;
      c_lo_val = 4'hF;
      c_hi_val = 4'h0;
      step();
      c_load = 1'b0;
      check("casc_load_0f", {hi_count, lo_count}, 8'h0F);
      c_en = 1'b1;
      #1;
      check("casc_lo_tc_0f", 8'(lo_tc), 8'd1);
      check("casc_hi_tc_0f", 8'(hi_tc), 8'd0);
      step();
      check("casc_count_10", {hi_count, lo_count}, 8'h10);
      check("casc_lo_wr_10", 8'(lo_wrapped), 8'd1);
      check("casc_hi_wr_10", 8'(hi_wrapped), 8'd0);

      // Cascade: 0xFF -> 0x00 with both wrap pulses
      c_en     = 1'b0;
      c_load   = 1'b1;
      c_lo_val = 4'hF;
      c_hi_val = 4'hF;
      step();
      c_load = 1'b0;
      check("casc_load_ff", {hi_count, lo_count}, 8'hFF);
      c_en = 1'b1;
      #1;
      check("casc_hi_tc_ff", 8'(hi_tc), 8'd1);
      step();
      check("casc_count_00", {hi_count, lo_count}, 8'h00);
      check("casc_lo_wr_00", 8'(lo_wrapped), 8'd1);
      check("casc_hi_wr_00", 8'(hi_wrapped), 8'd1);
      step();
      check("casc_count_01", {hi_count, lo_count}, 8'h01);
      check("casc_lo_wr_01", 8'(lo_wrapped), 8'd0);
      check("casc_hi_wr_01", 8'(hi_wrapped), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
